sll_iter_32: RTL
================

# sll_iter_32

Multi-cycle logical left shifter for the ALU's shift path. It resolves one shift-amount bit per cycle, MSB first (16, 8, 4, 2, 1), over five fixed cycles. It uses a valid/ready handshake on both sides, so it can sit behind the ALU operand latch and feed the writeback mux under backpressure. Optional signed-overflow detection lets the datapath flag lossy `sll` results.

## Interface
- `WIDTH`, 32: data width. Only 32 is supported.
- `SHAMT_W`, 5: shift-amount width, equal to log2(`WIDTH`).
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request.
- `data_operandA` in 32: operand to shift.
- `shamt` in 5: shift amount, 0–31.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out` out 32: shifted result.
- `overflow` out 1: signed overflow flag. Tied 0 unless `SLL_ITER_OVF_EN` is defined.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `data_operandA` into the accumulator and `shamt` into a shamt register; set stage=4 and the overflow flag=0; go to SHIFT.
- SHIFT
  - `in_ready`=0.
  - Each cycle: if `shamt_reg[stage]`, accumulator <<= 2^stage and zero-fill; otherwise hold.
  - stage decrements each cycle. After processing stage 0, go to DONE.
  - shamt=0 still takes all five SHIFT cycles; there is no early exit.
- DONE
  - `out_valid`=1; `out` and `overflow` are held stable.
  - On `out_ready`: go to IDLE. `out_valid` drops the next cycle.
  - `in_ready`=0 in DONE; there is no overlap of requests.
- Inputs are sampled only at the accept edge. Later changes to `data_operandA` or `shamt` have no effect on an accepted request.
- Reset, asserted at any time including mid-SHIFT or DONE, asynchronously forces:
  - state=IDLE;
  - `out`=0, `overflow`=0, `out_valid`=0;
  - `in_ready`=1 after deassertion.
- Reset values: `in_ready`=1, `out_valid`=0, `out`=32'h0, `overflow`=0.

## Timing
- Accept at edge E.
- SHIFT occupies edges E+1 through E+5.
- `out_valid` is high starting at edge E+5 and remains high through the handshake edge.
- Minimum issue interval: 7 cycles (accept, 5 shift, DONE handshake with `out_ready`=1).
- `out` is registered; there is no combinational path from inputs to outputs.
- `in_ready` and `out_valid` are decoded from the state register only.

## Configuration
- `SLL_ITER_OVF_EN` defined:
  - At each applied stage of shift k, `overflow` is set (sticky) if the top k+1 bits of the accumulator are not all equal.
  - Net effect: `overflow`=1 iff `data_operandA`×2^`shamt` is not representable as a signed 32-bit value.
  - `overflow` is valid with `out_valid`.
- `SLL_ITER_OVF_EN` undefined:
  - `overflow` is constant 0.
  - The detection logic and its flop are absent.
- Latency is identical in both builds.

## Structure
- Shared package `sll_iter_pkg`:
  - state enum (IDLE/SHIFT/DONE);
  - `WIDTH`, `SHAMT_W`, `LAST_STAGE`=0, `FIRST_STAGE`=4.
- Sub-module `sll_stage`: combinational shift by 2^stage, selected by the stage index, with the per-stage overflow check.
- The top level holds the FSM, stage counter, accumulator, shamt register and sticky overflow flag.

## Test plan
- `32'hDEADBEEF`, shamt 0 → `out`=`32'hDEADBEEF`, `overflow`=0, `out_valid` exactly at E+5.
- `32'h00000001`, shamt 31 → `out`=`32'h80000000`, `overflow`=1 (0 when the macro is off).
- `32'hFFFFFFFF`, shamt 4 → `out`=`32'hFFFFFFF0`, `overflow`=0.
- `32'h40000000`, shamt 1 → `out`=`32'h80000000`, `overflow`=1.
- Backpressure: `out_ready` held low for 3 cycles in DONE → `out` and `overflow` stable, `in_ready`=0, and a new `in_valid` is ignored until the handshake completes.
- Reset asserted at SHIFT stage 2 → immediate IDLE, `out`=0, `out_valid`=0. The next request `32'h3`, shamt 2 returns `32'hC`.

Source files
------------

// File: rtl/sll_iter_pkg.sv
// sll_iter_pkg: shared types and constants for the iterative left shifter.
//   WIDTH/SHAMT_W  datapath and shift-amount widths (32/5 only)
//   STAGE_W        width of the stage index counter
//   FIRST_STAGE    stage resolved first (shift by 16)
//   LAST_STAGE     stage resolved last (shift by 1)
//   state_t        control FSM states
package sll_iter_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STAGE_W = 3;

  localparam logic [STAGE_W-1:0] FIRST_STAGE = 3'd4;
  localparam logic [STAGE_W-1:0] LAST_STAGE  = 3'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sll_iter_if.sv
// sll_iter_if: request/response handshake bundle of the shifter.
//   in_valid/in_ready       request handshake
//   data_operandA, shamt    request payload
//   out_valid/out_ready     result handshake
//   out, overflow           result payload
// Modports: master = producer/consumer side (testbench, ALU), slave = shifter.
interface sll_iter_if;
  import sll_iter_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_operandA;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out;
  logic               overflow;

  modport master (
    output in_valid, data_operandA, shamt, out_ready,
    input  in_ready, out_valid, out, overflow
  );

  modport slave (
    input  in_valid, data_operandA, shamt, out_ready,
    output in_ready, out_valid, out, overflow
  );

endinterface

// File: rtl/sll_stage.sv
// sll_stage: one combinational step of the shifter. Shifts i_data left by
// 2^i_stage with zero fill when i_apply is set, otherwise passes it through.
// Ports:
//   i_data   accumulator value entering this step
//   i_stage  stage index (0..4), shift distance is 2^i_stage
//   i_apply  shamt bit for this stage
//   o_data   accumulator value after this step
//   o_ovf    (only with SLL_ITER_OVF_EN) this step loses signed information
module sll_stage
  import sll_iter_pkg::*;
(
  input  logic [WIDTH-1:0]   i_data,
  input  logic [STAGE_W-1:0] i_stage,
  input  logic               i_apply,
`ifdef SLL_ITER_OVF_EN
  output logic               o_ovf,
`endif
  output logic [WIDTH-1:0]   o_data
);

  logic [SHAMT_W-1:0] w_dist;

  assign w_dist = SHAMT_W'(1) << i_stage;
  assign o_data = i_apply ? (i_data << w_dist) : i_data;

`ifdef SLL_ITER_OVF_EN
  // A shift by k is lossless for a signed value only when the top k+1 bits
  // are all copies of the sign bit, i.e. all zeros or all ones.
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_top;

  assign w_mask = ~({WIDTH{1'b1}} >> (w_dist + SHAMT_W'(1)));
  assign w_top  = i_data & w_mask;
  assign o_ovf  = i_apply && (w_top != '0) && (w_top != w_mask);
`endif

endmodule

// File: rtl/sll_iter_32.sv
// sll_iter_32: multi-cycle logical left shifter, one shamt bit per cycle
// MSB first (16, 8, 4, 2, 1), five fixed SHIFT cycles per request.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-high reset, clears all state
//   bus     sll_iter_if.slave: valid/ready request in, valid/ready result out
// Optional macro SLL_ITER_OVF_EN enables sticky signed-overflow detection;
// without it overflow is tied 0 and the detection flop does not exist.
module sll_iter_32
  import sll_iter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  sll_iter_if.slave  bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_shamt;
  logic [STAGE_W-1:0] r_stage;
  logic [WIDTH-1:0]   w_stage_data;
  logic               w_accept;

  assign w_accept = (r_state == IDLE) && bus.in_valid;

  // Handshake outputs come straight from the state register.
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out       = r_acc;

`ifdef SLL_ITER_OVF_EN
  logic w_stage_ovf;
  logic r_ovf;
`endif

  sll_stage u_stage (
    .i_data  (r_acc),
    .i_stage (r_stage),
    .i_apply (r_shamt[r_stage]),
`ifdef SLL_ITER_OVF_EN
    .o_ovf   (w_stage_ovf),
`endif
    .o_data  (w_stage_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = SHIFT;
      SHIFT:   if (r_stage == LAST_STAGE) w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Accumulator and stage counter. The accumulator doubles as the output
  // register, so it is held untouched through DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_shamt <= '0;
      r_stage <= FIRST_STAGE;
    end else if (w_accept) begin
      r_acc   <= bus.data_operandA;
      r_shamt <= bus.shamt;
      r_stage <= FIRST_STAGE;
    end else if (r_state == SHIFT) begin
      r_acc <= w_stage_data;
      if (r_stage != LAST_STAGE) begin
        r_stage <= r_stage - STAGE_W'(1);
      end
    end
  end

`ifdef SLL_ITER_OVF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_ovf <= r_ovf | w_stage_ovf;
    end
  end

  assign bus.overflow = r_ovf;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule
